// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between the fetch and data stages.
// A transaction drives the memory for WAIT_CYCLES cycles (BUSY), then pulses
// the owner's ready for one cycle (DONE) and returns to IDLE.
// Optional feature: define ROUND_ROBIN_EN to alternate grants when both
// requesters compete; otherwise the data stage always wins a conflict.
module mem_arbiter #(
  parameter int unsigned WAIT_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ready,
  output logic [31:0] if_rdata,
  input  logic        MEM_R_EN,
  input  logic        MEM_W_EN,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ready,
  output logic [31:0] d_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_re,
  output logic        mem_we,
  input  logic [31:0] mem_rdata,
  output logic        if_stall,
  output logic        d_stall,
  output logic        busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [3:0] CNT_LOAD    = 4'(WAIT_CYCLES - 1);
  localparam logic       OWNER_FETCH = 1'b0;
  localparam logic       OWNER_DATA  = 1'b1;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        owner_q, owner_d;
  logic        wr_q, wr_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;

  // Registered copies of the externally visible strobes and bus values
  logic        mem_re_q, mem_re_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        if_ready_q, if_ready_d;
  logic        d_ready_q, d_ready_d;
  logic        busy_q, busy_d;

  logic        d_req_s;
  logic        grant_data_s;

`ifdef ROUND_ROBIN_EN
  logic        last_grant_q, last_grant_d;
`endif

  // Arbitration: pick the winner among the requests present this cycle
  always_comb begin
    d_req_s      = MEM_R_EN | MEM_W_EN;
    grant_data_s = d_req_s;
`ifdef ROUND_ROBIN_EN
    if (d_req_s && if_req) begin
      // The requester that did not win last time goes first
      grant_data_s = (last_grant_q == OWNER_FETCH);
    end else begin
      grant_data_s = d_req_s;
    end
`endif
  end

  // Next-state logic: transaction sequencing, latching and read capture
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    owner_d    = owner_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
`ifdef ROUND_ROBIN_EN
    last_grant_d = last_grant_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (if_req || d_req_s) begin
          state_d = ST_BUSY;
          cnt_d   = CNT_LOAD;
          owner_d = grant_data_s ? OWNER_DATA : OWNER_FETCH;
          addr_d  = grant_data_s ? d_addr : if_addr;
          wdata_d = grant_data_s ? d_wdata : 32'd0;
          // Read and write together count as a write
          wr_d    = grant_data_s & MEM_W_EN;
`ifdef ROUND_ROBIN_EN
          last_grant_d = grant_data_s ? OWNER_DATA : OWNER_FETCH;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_DONE;
          if (!wr_q) begin
            if (owner_q == OWNER_DATA) begin
              d_rdata_d = mem_rdata;
            end else begin
              if_rdata_d = mem_rdata;
            end
          end else begin
            // Writes leave both read-data registers untouched
            d_rdata_d = d_rdata_q;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode from the upcoming state so every output leaves a flop
  always_comb begin
    mem_re_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = 32'd0;
    mem_wdata_d = 32'd0;
    if_ready_d  = 1'b0;
    d_ready_d   = 1'b0;
    busy_d      = (state_d != ST_IDLE);
    if (state_d == ST_BUSY) begin
      mem_re_d    = ~wr_d;
      mem_we_d    = wr_d;
      mem_addr_d  = addr_d;
      mem_wdata_d = wdata_d;
    end else if (state_d == ST_DONE) begin
      if_ready_d = (owner_d == OWNER_FETCH);
      d_ready_d  = (owner_d == OWNER_DATA);
    end else begin
      busy_d = 1'b0;
    end
  end

  // State and output registers; reset wins over everything else
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      owner_q     <= OWNER_FETCH;
      wr_q        <= 1'b0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      if_rdata_q  <= 32'd0;
      d_rdata_q   <= 32'd0;
      mem_re_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      if_ready_q  <= 1'b0;
      d_ready_q   <= 1'b0;
      busy_q      <= 1'b0;
`ifdef ROUND_ROBIN_EN
      last_grant_q <= OWNER_FETCH;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      owner_q     <= owner_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      mem_re_q    <= mem_re_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_ready_q  <= if_ready_d;
      d_ready_q   <= d_ready_d;
      busy_q      <= busy_d;
`ifdef ROUND_ROBIN_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  assign mem_re    = mem_re_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_ready  = if_ready_q;
  assign d_ready   = d_ready_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign busy      = busy_q;

  // Stalls follow the live request and the registered ready pulse
  assign if_stall = if_req & ~if_ready_q;
  assign d_stall  = (MEM_R_EN | MEM_W_EN) & ~d_ready_q;

endmodule
